chi2_best_sel: RTL and testbench
================================

CHI2_BEST_SEL -- requirements
Module: chi2_best_sel

Interface
REQ-001 Parameter CHI2_W, default 16, chi-square word width (unsigned).
REQ-002 Parameter NCOMB, default 6, number of fit combinations per track; legal sel_chi values are 0..NCOMB-1.
REQ-003 clock  in  1  single rising-edge clock for the whole block.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 comb_valid  in  1  one combination result is presented this cycle.
REQ-006 comb_first  in  1  qualifies comb_valid: first combination of a track.
REQ-007 comb_last  in  1  qualifies comb_valid: last combination of a track.
REQ-008 sel_chi  in  3  combination index of the presented result.
REQ-009 chi2  in  CHI2_W  chi-square of the presented combination.
REQ-010 hitmap  in  5  layer hitmap of the combination, already aligned to chi2 by the upstream 2-cycle mux delay.
REQ-011 lcmap  in  5  long-cluster map of the combination, aligned like hitmap.
REQ-012 chi2_max  in  CHI2_W  quasi-static acceptance threshold.
REQ-013 in_ready  out  1  block accepts comb_valid this cycle.
REQ-014 best_valid  out  1  best-combination result held for the consumer.
REQ-015 out_ready  in  1  consumer takes the result when it is high together with best_valid.
REQ-016 best_sel  out  3  index of the winning combination.
REQ-017 best_chi2  out  CHI2_W  chi-square of the winner.
REQ-018 best_hitmap / best_lcmap  out  5 each  maps of the winner.
REQ-019 best_pass  out  1  best_chi2 <= chi2_max, sampled when the last combination is accepted.
REQ-020 best_ncomb  out  3  number of combinations accepted for this track.
REQ-021 seq_err  out  1  sticky protocol-error flag; cleared only by reset.

Function
REQ-022 The block SHALL use three states: IDLE, ACCUM, HOLD.
REQ-023 in_ready SHALL be 1 in IDLE and ACCUM; in HOLD it SHALL equal out_ready.
REQ-024 A combination is accepted when comb_valid & in_ready & sel_chi < NCOMB.
REQ-025 IDLE, accept with comb_first: load the candidate (sel, chi2, maps) and set count=1. Next state is HOLD if comb_last, else ACCUM.
REQ-026 ACCUM, accept without comb_first: replace the candidate only if chi2 < candidate chi2 (strict compare, so a tie keeps the earlier combination) and increment count. Next state is HOLD if comb_last.
REQ-027 ACCUM, accept with comb_first: discard the candidate, restart as in REQ-025, and set seq_err.
REQ-028 Accept with count = NCOMB already and no comb_last: treat as comb_last (go to HOLD with the result updated) and set seq_err.
REQ-029 IDLE, comb_valid without comb_first: ignore it and set seq_err.
REQ-030 comb_valid with sel_chi >= NCOMB: ignore it in any state and set seq_err.
REQ-031 On entry to HOLD the registered outputs SHALL update on the same edge that accepts the last combination, so best_valid rises one cycle after the last combination is presented.
REQ-032 HOLD: the outputs SHALL stay stable until best_valid & out_ready. Then the state returns to IDLE.
REQ-033 HOLD, handshake in the same cycle as an accepted comb_first: start the new track (REQ-025) with no bubble.
REQ-034 HOLD, comb_valid without a handshake: the combination is not accepted (in_ready=0), so the upstream must hold it; no error.
REQ-035 best_pass SHALL be computed with an unsigned compare of full CHI2_W width.
REQ-036 count SHALL saturate at NCOMB.

Reset
REQ-037 reset_n low SHALL immediately force the following: state IDLE, best_valid=0, best_sel=0, best_chi2=0, best_hitmap=0, best_lcmap=0, best_pass=0, best_ncomb=0, seq_err=0, internal count=0.
REQ-038 Reset asserted mid-track SHALL discard the partial track. No result is emitted for it.

Structure
REQ-039 CHI2_W, NCOMB and the state encoding SHALL reside in the shared package gf_fit_pkg.
REQ-040 The strict-less compare with the tie rule SHALL be one sub-module, chi2_cmp, instantiated once.

Verification
REQ-041 Track with 6 combinations, chi2 = 40,25,25,90,10,30, chi2_max=20 -> best_sel=4, best_chi2=10, best_pass=1, best_ncomb=6, best_valid rises 1 cycle after the last input.
REQ-042 Track with chi2 = 7,7,7,7,7,7 -> best_sel=0 (tie keeps the first), best_pass=(7<=chi2_max).
REQ-043 out_ready held 0 for 5 cycles in HOLD while the next comb_first is presented -> in_ready=0, outputs stable. On out_ready=1 the new track starts the same cycle with no bubble.
REQ-044 comb_first arrives at the third combination of a track -> the track restarts, seq_err=1, and only the second track's result is emitted.
REQ-045 sel_chi=6 with comb_valid -> ignored, seq_err=1. A separate case: reset_n pulsed low mid-ACCUM -> all outputs 0 and no best_valid for that track.

Source files
------------

// File: rtl/gf_fit_pkg.sv
// Shared widths and FSM encoding for the track-fit best-combination selector.
package gf_fit_pkg;

    localparam int GF_CHI2_W = 16;
    localparam int GF_NCOMB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } fit_state_t;

endpackage

// File: rtl/chi2_cmp.sv
// Strict-less chi-square compare: a tie keeps the current (earlier) candidate.
module chi2_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] chi2_new,
    input  logic [W-1:0] chi2_cur,
    output logic         take_new
);

    assign take_new = chi2_new < chi2_cur;

endmodule

// File: rtl/chi2_best_sel.sv
// Picks the minimum-chi2 fit combination of a track and holds it for the consumer.
module chi2_best_sel
    import gf_fit_pkg::*;
#(
    parameter int CHI2_W = GF_CHI2_W,
    parameter int NCOMB  = GF_NCOMB
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              comb_valid,
    input  logic              comb_first,
    input  logic              comb_last,
    input  logic [2:0]        sel_chi,
    input  logic [CHI2_W-1:0] chi2,
    input  logic [4:0]        hitmap,
    input  logic [4:0]        lcmap,
    input  logic [CHI2_W-1:0] chi2_max,
    output logic              in_ready,
    output logic              best_valid,
    input  logic              out_ready,
    output logic [2:0]        best_sel,
    output logic [CHI2_W-1:0] best_chi2,
    output logic [4:0]        best_hitmap,
    output logic [4:0]        best_lcmap,
    output logic              best_pass,
    output logic [2:0]        best_ncomb,
    output logic              seq_err
);

    localparam logic [2:0] NCOMB3 = 3'(NCOMB);

    fit_state_t        state, state_nx;
    logic [2:0]        cand_sel, count, nx_sel, nx_count;
    logic [CHI2_W-1:0] cand_chi2, nx_chi2;
    logic [4:0]        cand_hit, cand_lc, nx_hit, nx_lc;
    logic              sel_ok, accept, start, cont, stray, overrun, finish;
    logic              take_new, take, err_now;

    chi2_cmp #(.W(CHI2_W)) u_cmp (
        .chi2_new (chi2),
        .chi2_cur (cand_chi2),
        .take_new (take_new)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        in_ready = (state == ST_HOLD) ? out_ready : 1'b1;
        sel_ok   = sel_chi < NCOMB3;
        accept   = comb_valid & in_ready & sel_ok;
        // A first always restarts; a non-first only counts while accumulating.
        start    = accept & comb_first;
        cont     = accept & ~comb_first & (state == ST_ACCUM);
        stray    = accept & ~comb_first & (state != ST_ACCUM);
        overrun  = cont & (count == NCOMB3) & ~comb_last;
        finish   = ((start | cont) & comb_last) | overrun;
        err_now  = (comb_valid & ~sel_ok) | stray | overrun | (start & (state == ST_ACCUM));
        take     = start | (cont & take_new);
        nx_sel   = take ? sel_chi : cand_sel;
        nx_chi2  = take ? chi2    : cand_chi2;
        nx_hit   = take ? hitmap  : cand_hit;
        nx_lc    = take ? lcmap   : cand_lc;
        nx_count = start ? 3'd1 : (count == NCOMB3) ? count : count + 3'd1;

        state_nx = state;
        if (finish)                             state_nx = ST_HOLD;
        else if (start | cont)                  state_nx = ST_ACCUM;
        else if (state == ST_HOLD && out_ready) state_nx = ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_sel    <= '0;
            cand_chi2   <= '0;
            cand_hit    <= '0;
            cand_lc     <= '0;
            count       <= '0;
            best_valid  <= 1'b0;
            best_sel    <= '0;
            best_chi2   <= '0;
            best_hitmap <= '0;
            best_lcmap  <= '0;
            best_pass   <= 1'b0;
            best_ncomb  <= '0;
            seq_err     <= 1'b0;
        end else begin
            if (start | cont) begin
                cand_sel  <= nx_sel;
                cand_chi2 <= nx_chi2;
                cand_hit  <= nx_hit;
                cand_lc   <= nx_lc;
                count     <= nx_count;
            end
            // Result registers load on the accepting edge of the last combination.
            if (finish) begin
                best_sel    <= nx_sel;
                best_chi2   <= nx_chi2;
                best_hitmap <= nx_hit;
                best_lcmap  <= nx_lc;
                best_pass   <= nx_chi2 <= chi2_max;
                best_ncomb  <= nx_count;
            end
            best_valid <= state_nx == ST_HOLD;
            if (err_now) seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_chi2_best_sel.sv
// Directed and randomized bench for chi2_best_sel against an argmin reference model.
module tb_chi2_best_sel;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        comb_valid = 1'b0, comb_first = 1'b0, comb_last = 1'b0;
    logic [2:0]  sel_chi = '0;
    logic [15:0] chi2 = '0;
    logic [4:0]  hitmap = '0, lcmap = '0;
    logic [15:0] chi2_max = '0;
    logic        in_ready, best_valid, out_ready = 1'b0;
    logic [2:0]  best_sel, best_ncomb;
    logic [15:0] best_chi2;
    logic [4:0]  best_hitmap, best_lcmap;
    logic        best_pass, seq_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the combinations of the current track, in arrival order.
    int q_s[$];
    int q_c[$];
    int q_h[$];
    int q_l[$];

    chi2_best_sel dut (
        .clock(clock), .reset_n(reset_n), .comb_valid(comb_valid), .comb_first(comb_first),
        .comb_last(comb_last), .sel_chi(sel_chi), .chi2(chi2), .hitmap(hitmap), .lcmap(lcmap),
        .chi2_max(chi2_max), .in_ready(in_ready), .best_valid(best_valid), .out_ready(out_ready),
        .best_sel(best_sel), .best_chi2(best_chi2), .best_hitmap(best_hitmap),
        .best_lcmap(best_lcmap), .best_pass(best_pass), .best_ncomb(best_ncomb), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_s.delete(); q_c.delete(); q_h.delete(); q_l.delete();
    endtask

    task automatic model_push(input int s, input int c, input int h, input int l);
        q_s.push_back(s); q_c.push_back(c); q_h.push_back(h); q_l.push_back(l);
    endtask

    // Present one combination and wait until it is accepted; a first restarts the model track.
    task automatic send(input logic f, input logic l, input int s, input int c, input int h, input int m);
        int guard;
        guard = 0;
        comb_valid = 1'b1; comb_first = f; comb_last = l;
        sel_chi = 3'(s); chi2 = 16'(c); hitmap = 5'(h); lcmap = 5'(m);
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        comb_valid = 1'b0; comb_first = 1'b0; comb_last = 1'b0;
        if (f) model_clear();
        model_push(s, c, h, m);
    endtask

    // Expected result: first minimum over the track, count saturating at six.
    task automatic check_result(input string tag);
        int bi;
        int nc;
        bi = 0;
        for (int i = 1; i < q_c.size(); i++) if (q_c[i] < q_c[bi]) bi = i;
        nc = (q_c.size() > 6) ? 6 : q_c.size();
        check({tag, "_valid"}, 32'(best_valid), 32'd1);
        check({tag, "_sel"},   32'(best_sel),   32'(q_s[bi]));
        check({tag, "_chi2"},  32'(best_chi2),  32'(q_c[bi]));
        check({tag, "_hit"},   32'(best_hitmap), 32'(q_h[bi]));
        check({tag, "_lc"},    32'(best_lcmap), 32'(q_l[bi]));
        check({tag, "_pass"},  32'(best_pass),  32'(q_c[bi] <= int'(chi2_max)));
        check({tag, "_ncomb"}, 32'(best_ncomb), 32'(nc));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("consume_drop", 32'(best_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        model_clear();
    endtask

    initial begin
        int c41[6];
        // Reset state, observed while reset is held.
        #2;
        check("rst_valid", 32'(best_valid), 32'd0);
        check("rst_sel",   32'(best_sel),   32'd0);
        check("rst_chi2",  32'(best_chi2),  32'd0);
        check("rst_maps",  32'({best_hitmap, best_lcmap}), 32'd0);
        check("rst_pass",  32'(best_pass),  32'd0);
        check("rst_ncomb", 32'(best_ncomb), 32'd0);
        check("rst_err",   32'(seq_err),    32'd0);
        check("rst_ready", 32'(in_ready),   32'd1);
        do_reset();

        // Six combinations, unique minimum at index 4.
        chi2_max = 16'd20;
        c41 = '{40, 25, 25, 90, 10, 30};
        for (int i = 0; i < 5; i++) send(i == 0, 1'b0, i, c41[i], i + 1, 5'h1f - i);
        check("t41_not_yet", 32'(best_valid), 32'd0);
        send(1'b0, 1'b1, 5, c41[5], 6, 26);
        check_result("t41");
        check("t41_err", 32'(seq_err), 32'd0);
        consume();

        // All ties: the first combination wins.
        for (int i = 0; i < 6; i++) send(i == 0, i == 5, i, 7, 3 + i, 9 + i);
        check_result("t42");

        // Consumer stalls while the next first waits; starts with no bubble on the handshake.
        comb_valid = 1'b1; comb_first = 1'b1; comb_last = 1'b0;
        sel_chi = 3'd0; chi2 = 16'd12; hitmap = 5'd2; lcmap = 5'd4;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("t43_ready_low", 32'(in_ready), 32'd0);
            check("t43_hold_sel",  32'(best_sel), 32'd0);
            check("t43_hold_chi2", 32'(best_chi2), 32'd7);
            check("t43_hold_vld",  32'(best_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t43_ready_hs", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b0; comb_valid = 1'b0; comb_first = 1'b0;
        model_clear();
        model_push(0, 12, 2, 4);
        check("t43_vld_drop", 32'(best_valid), 32'd0);
        chi2_max = 16'd9;
        send(1'b0, 1'b1, 1, 9, 17, 3);
        check_result("t43b");
        consume();

        // Single-combination track just over threshold.
        send(1'b1, 1'b1, 3, 10, 5, 6);
        check_result("t_single");
        consume();

        // Restart at the third combination: only the second track is reported.
        chi2_max = 16'd25;
        send(1'b1, 1'b0, 0, 50, 1, 1);
        send(1'b0, 1'b0, 1, 60, 2, 2);
        send(1'b1, 1'b0, 0, 30, 3, 3);
        check("t44_err", 32'(seq_err), 32'd1);
        check("t44_no_vld", 32'(best_valid), 32'd0);
        send(1'b0, 1'b1, 1, 20, 4, 4);
        check_result("t44");
        consume();

        // Seven combinations without a last: the seventh closes the track.
        for (int i = 0; i < 6; i++) send(i == 0, 1'b0, i, 9 - i, i, i);
        check("ovr_no_vld", 32'(best_valid), 32'd0);
        send(1'b0, 1'b0, 2, 3, 21, 22);
        check_result("ovr");
        consume();

        // Reset mid-track clears everything immediately and emits nothing.
        send(1'b1, 1'b0, 0, 5, 1, 1);
        send(1'b0, 1'b0, 1, 4, 2, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sel",  32'(best_sel),  32'd0);
        check("mid_rst_chi2", 32'(best_chi2), 32'd0);
        check("mid_rst_err",  32'(seq_err),   32'd0);
        check("mid_rst_ncmb", 32'(best_ncomb), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check("mid_rst_novld", 32'(best_valid), 32'd0);
        end
        model_clear();

        // Non-first while idle is ignored and flagged.
        comb_valid = 1'b1; comb_first = 1'b0; comb_last = 1'b1; sel_chi = 3'd1; chi2 = 16'd3;
        @(posedge clock); #1;
        comb_valid = 1'b0; comb_last = 1'b0;
        check("stray_no_vld", 32'(best_valid), 32'd0);
        check("stray_err",    32'(seq_err),    32'd1);
        do_reset();

        // Out-of-range combination index is ignored and flagged.
        comb_valid = 1'b1; comb_first = 1'b1; comb_last = 1'b1; sel_chi = 3'd6; chi2 = 16'd1;
        @(posedge clock); #1;
        comb_valid = 1'b0; comb_first = 1'b0; comb_last = 1'b0;
        check("badsel_no_vld", 32'(best_valid), 32'd0);
        check("badsel_err",    32'(seq_err),    32'd1);
        do_reset();

        // Random well-formed tracks with narrow chi2 range to provoke ties and threshold edges.
        for (int t = 0; t < 25; t++) begin
            int n;
            int stall;
            n = int'($urandom_range(1, 6));
            chi2_max = 16'($urandom_range(0, 15));
            for (int i = 0; i < n; i++)
                send(i == 0, i == n - 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            check_result("rnd");
            stall = int'($urandom_range(0, 3));
            for (int k = 0; k < stall; k++) begin
                @(posedge clock); #1;
                check("rnd_stable", 32'(best_chi2), 32'(q_c.min()[0]));
            end
            consume();
        end
        check("rnd_no_err", 32'(seq_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
